mdu_hilo: RTL and testbench
===========================

Name: mdu_hilo

Overview:
- Parametrised multi-cycle multiply/divide unit owning the HI/LO register pair for the MIPS pipeline's EX stage.
- Executes the mult/multu/div/divu and mthi/mtlo instruction classes flagged by the control decoder.
- Exposes a busy flag that the hazard logic uses to stall mfhi/mflo and further MDU instructions.
- Replaces the fixed single-cycle HI/LO path with configurable width and per-operation latency.

Parameters:
WIDTH, 32, operand and HI/LO register width in bits (legal values: 8 or more)
MULT_CYCLES, 5, busy cycles for mult/multu (legal values: 1 or more)
DIV_CYCLES, 10, busy cycles for div/divu (legal values: 1 or more)

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous active-high reset
start  input  1  request qualifier; op/a/b are sampled on a rising edge when start=1
op  input  3  operation: 000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, 110/111 reserved
a  input  WIDTH  rs operand (multiplicand, dividend, or mt source)
b  input  WIDTH  rt operand (multiplier or divisor)
busy  output  1  an operation is in flight; HI/LO are not yet valid
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset:
  - Asynchronous: busy=0, hi=0, lo=0, FSM state IDLE, cycle counter=0.
  - Reset asserted mid-operation aborts the operation; no result is ever written.
- FSM states: IDLE, RUN.
- Acceptance:
  - In IDLE, start=1 with op in {000..011} is accepted at edge k.
  - Operands and op are latched, counter loads MULT_CYCLES or DIV_CYCLES, and the FSM enters RUN.
  - busy=1 in the cycles after edges k..k+N-1, i.e. exactly N cycles.
- Completion:
  - At edge k+N, hi/lo take the result, busy drops to 0 and the FSM returns to IDLE, all on the same edge.
  - A new start sampled at that same edge k+N is ignored, because busy is still 1 at that edge.
- RUN:
  - The counter decrements each edge.
  - start is ignored while busy=1; there is no queueing. The stall logic guarantees no request is issued, and the bench checks that one would be dropped.
- mthi/mtlo:
  - Accepted only in IDLE.
  - Single edge: hi<=a (mthi) or lo<=a (mtlo); the other register is unchanged.
  - busy stays 0.
- Reserved op: ignored; no state change.
- Multiply:
  - Full 2*WIDTH product: {hi,lo} = a*b.
  - mult treats a and b as two's-complement; multu treats them as unsigned.
- Divide, quotient and remainder:
  - lo=quotient, hi=remainder.
  - div is signed, with the quotient truncated toward zero and the remainder taking the sign of the dividend.
  - divu is unsigned.
- Divide boundary cases:
  - Divide by zero (b=0, div or divu): full latency still elapses; hi and lo are unchanged at completion.
  - Signed overflow (a = most negative value, b = -1): lo = most negative value, hi = 0.
- Implementation freedom:
  - The result may be computed combinationally at acceptance and held, or computed iteratively.
  - Only the edge at which hi/lo change and the busy waveform are normative.
- hi/lo change only:
  - at an operation's completion edge;
  - at an accepted mthi/mtlo;
  - at reset.

Test Plan:
1. Reset then idle: reset pulse, then 3 cycles with start=0 -> busy=0, hi=0, lo=0 throughout.
2. Signed multiply latency: mult a=0xFFFFFFFE (-2), b=3, default params -> busy=1 for exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA, with busy falling on the same edge.
3. Unsigned multiply: multu a=0xFFFFFFFF, b=2 -> hi=0x00000001, lo=0xFFFFFFFE after 5 busy cycles.
4. Signed division:
   - div a=-7 (0xFFFFFFF9), b=2 -> after 10 busy cycles lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
   - A second start issued mid-RUN (mtlo a=0x55) is ignored; lo is never 0x55.
5. Divide boundaries:
   - mthi 0x12, mtlo 0x34 (busy stays 0, values immediate).
   - Then divu b=0 -> 10 busy cycles, hi=0x12, lo=0x34 unchanged.
   - Then div a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
6. Reset mid-operation and reparametrisation:
   - divu started; reset asserted asynchronously in busy cycle 4 -> busy=0, hi=lo=0 immediately; no late write follows.
   - Repeat test 2 with WIDTH=16, MULT_CYCLES=1: busy high for 1 cycle, hi=0xFFFF, lo=0xFFFA.

Source files
------------

// File: rtl/mdu_hilo.sv
// Multi-cycle multiply/divide unit owning the HI/LO pair. The result is formed
// at acceptance and committed to HI/LO when the configured latency expires.
module mdu_hilo #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW         = $clog2(MAX_CYCLES + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;
  logic             res_wr;

  logic             is_signed;
  logic             a_neg;
  logic             b_neg;
  logic [2*WIDTH-1:0] mul_a;
  logic [2*WIDTH-1:0] mul_b;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] div_n;
  logic [WIDTH-1:0] div_d;
  logic [WIDTH-1:0] uq;
  logic [WIDTH-1:0] ur;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;

  // Shared multiplier/divider datapath; signed ops use extended operands or magnitudes
  always_comb begin
    is_signed = ~op[0];
    a_neg     = is_signed & a[WIDTH-1];
    b_neg     = is_signed & b[WIDTH-1];
    mul_a     = {{WIDTH{a_neg}}, a};
    mul_b     = {{WIDTH{b_neg}}, b};
    prod      = mul_a * mul_b;
    div_n     = a_neg ? -a : a;
    div_d     = b_neg ? -b : b;
    uq        = '0;
    ur        = '0;
    if (div_d != '0) begin
      uq = div_n / div_d;
      ur = div_n % div_d;
    end
    // Most-negative / -1 yields magnitude 2^(W-1), which already wraps to the required value
    quo = (a_neg ^ b_neg) ? -uq : uq;
    rem = a_neg ? -ur : ur;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      busy   <= 1'b0;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      res_hi <= '0;
      res_lo <= '0;
      res_wr <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            case (op)
              3'b000, 3'b001, 3'b010, 3'b011: begin
                res_hi <= op[1] ? rem : prod[2*WIDTH-1:WIDTH];
                res_lo <= op[1] ? quo : prod[WIDTH-1:0];
                // Divide by zero runs the full latency but leaves HI/LO untouched
                res_wr <= ~op[1] | (b != '0);
                cnt    <= op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                state  <= RUN;
                busy   <= 1'b1;
              end
              3'b100:  hi <= a;
              3'b101:  lo <= a;
              default: ;
            endcase
          end
        end
        RUN: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state <= IDLE;
            busy  <= 1'b0;
            if (res_wr) begin
              hi <= res_hi;
              lo <= res_lo;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_hilo.sv
// Randomised and directed bench for mdu_hilo: an arithmetic reference model feeds
// a scoreboard queue that a negedge monitor drains while checking busy/HI/LO.
module tb_mdu_hilo;

  localparam int unsigned MULT_N = 5;
  localparam int unsigned DIV_N  = 10;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        wr;
    int          left;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  logic        start16 = 1'b0;
  logic [2:0]  op16 = 3'd0;
  logic [15:0] a16 = '0;
  logic [15:0] b16 = '0;
  logic        busy16;
  logic [15:0] hi16;
  logic [15:0] lo16;

  exp_t        sb[$];
  logic [31:0] hi_m = '0;
  logic [31:0] lo_m = '0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  mdu_hilo dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .hi(hi), .lo(lo)
  );

  mdu_hilo #(.WIDTH(16), .MULT_CYCLES(1), .DIV_CYCLES(10)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .op(op16), .a(a16), .b(b16),
    .busy(busy16), .hi(hi16), .lo(lo16)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic on 64-bit integers
  function automatic exp_t model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t        e;
    longint      sx;
    longint      sy;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    e.wr = 1'b1;
    e.hi = '0;
    e.lo = '0;
    e.left = (o[1]) ? DIV_N : MULT_N;
    case (o)
      3'b000: p = 64'(sx * sy);
      3'b001: p = 64'(x) * 64'(y);
      3'b010: p = (y == 0) ? 64'd0 : {64'(sx % sy)} << 32 | {32'd0, 32'(sx / sy)};
      default: p = (y == 0) ? 64'd0 : {y == 0 ? 32'd0 : x % y, y == 0 ? 32'd0 : x / y};
    endcase
    if (o[1] && y == 0) e.wr = 1'b0;
    e.hi = p[63:32];
    e.lo = p[31:0];
    return e;
  endfunction

  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    if (sb.size() == 0) begin
      if (o <= 3'd3) sb.push_back(model(o, x, y));
      else if (o == 3'd4) hi_m = x;
      else if (o == 3'd5) lo_m = x;
    end
    #1 start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL wait_idle: scoreboard still holds %0d entries", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  // Monitor: retire completed entries, then check busy/HI/LO against the model
  always @(negedge clk) begin
    if (!reset) begin
      if (sb.size() != 0 && sb[0].left == 0) begin
        if (sb[0].wr) begin
          hi_m = sb[0].hi;
          lo_m = sb[0].lo;
        end
        void'(sb.pop_front());
      end
      if (sb.size() != 0) sb[0].left--;
      chk("busy", 32'(busy), 32'(sb.size() != 0));
      chk("hi", hi, hi_m);
      chk("lo", lo, lo_m);
    end
  end

  initial begin
    logic [2:0]  o;
    logic [31:0] x;
    logic [31:0] y;

    // 1: reset then idle
    #12 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_hi16", 32'(hi16), 32'h0);
    chk("reset_lo16", 32'(lo16), 32'h0);

    // 2: signed multiply
    issue(3'd0, 32'hFFFF_FFFE, 32'd3);
    wait_idle();
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFA);

    // 3: unsigned multiply
    issue(3'd1, 32'hFFFF_FFFF, 32'd2);
    wait_idle();
    chk("multu_hi", hi, 32'h0000_0001);
    chk("multu_lo", lo, 32'hFFFF_FFFE);

    // 4: signed divide with a dropped mtlo mid-run
    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    repeat (2) @(negedge clk);
    issue(3'd5, 32'h55, 32'h0);
    wait_idle();
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);

    // 5: mthi/mtlo, divide by zero, signed overflow
    issue(3'd4, 32'h12, 32'h0);
    issue(3'd5, 32'h34, 32'h0);
    @(negedge clk);
    chk("mt_hi", hi, 32'h12);
    chk("mt_lo", lo, 32'h34);
    issue(3'd3, 32'h99, 32'h0);
    wait_idle();
    chk("div0_hi", hi, 32'h12);
    chk("div0_lo", lo, 32'h34);
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle();
    chk("ovf_lo", lo, 32'h8000_0000);
    chk("ovf_hi", hi, 32'h0);

    // Reserved op leaves state alone
    issue(3'd6, 32'hDEAD_BEEF, 32'h3);
    issue(3'd7, 32'hDEAD_BEEF, 32'h3);
    repeat (2) @(negedge clk);

    // 6a: reset in busy cycle 4 of a divu
    issue(3'd3, 32'd1000, 32'd7);
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    sb.delete();
    hi_m = '0;
    lo_m = '0;
    @(negedge clk);
    #2 reset = 1'b0;
    repeat (15) @(negedge clk);

    // 6b: 16-bit instance with single-cycle multiply
    @(negedge clk);
    start16 = 1'b1; op16 = 3'd0; a16 = 16'hFFFE; b16 = 16'd3;
    @(posedge clk);
    #1 start16 = 1'b0;
    @(negedge clk);
    chk("w16_busy1", 32'(busy16), 32'h1);
    @(negedge clk);
    chk("w16_busy0", 32'(busy16), 32'h0);
    chk("w16_hi", 32'(hi16), 32'h0000_FFFF);
    chk("w16_lo", 32'(lo16), 32'h0000_FFFA);

    // Random traffic, including starts that land while busy
    for (int i = 0; i < 80; i++) begin
      o = 3'($urandom_range(0, 7));
      x = $urandom();
      y = $urandom();
      if ($urandom_range(0, 7) == 0) x = 32'h8000_0000;
      case ($urandom_range(0, 9))
        0: y = 32'h0;
        1: y = 32'hFFFF_FFFF;
        2: y = 32'($urandom_range(1, 15));
        default: ;
      endcase
      issue(o, x, y);
      repeat ($urandom_range(0, 12)) @(negedge clk);
    end
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
